// File: rtl/trap_sequencer.sv
// Interrupt trap entry sequencer: pushes PC and status, fetches the vector, then commits.
// Build option TRAP_SEQ_IE_CLR_EN: COMMIT also writes status low byte with IE and SLP cleared.
module trap_sequencer #(
  parameter int              WORD     = 16,
  parameter int              PLVLS    = 8,
  parameter logic [WORD-1:0] VEC_BASE = 16'hFFC0,
  localparam int             PW       = $clog2(PLVLS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PLVLS-1:0]    irq_i,
  input  logic                instBoundary_i,
  input  logic [WORD-1:0]     status_i,
  input  logic [WORD-1:0]     pc_i,
  input  logic [WORD-1:0]     sp_i,
  output logic                memReq_o,
  output logic                memWr_o,
  output logic [WORD-1:0]     memAddr_o,
  output logic [WORD-1:0]     memData_o,
  input  logic                memAck_i,
  input  logic [WORD-1:0]     memData_i,
  output logic                trapActive_o,
  output logic                pcWr_o,
  output logic [WORD-1:0]     pcData_o,
  output logic                spWr_o,
  output logic [WORD-1:0]     spData_o,
  output logic                setPriv_o,
  output logic [PW-1:0]       priv_o,
  output logic                clrSlp_o,
  output logic [PLVLS-1:0]    irqAck_o,
  output logic [WORD/8-1:0]   srWrEn_o,
  output logic [WORD-1:0]     srData_o
);

  typedef enum logic [2:0] {IDLE, PUSH_PC, PUSH_SR, RD_VEC, COMMIT} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   n_q, n_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] sp_q, sp_d;
  logic [WORD-1:0] sr_q, sr_d;
  logic [WORD-1:0] vec_q, vec_d;

  logic            win_valid;
  logic [PW-1:0]   win_idx;

  // Ascending scan so the highest eligible index is the one left standing.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < PLVLS; i++) begin
      if (irq_i[i] && status_i[5] && (i > 32'(status_i[15:13]))) begin
        win_valid = 1'b1;
        win_idx   = PW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    pc_d         = pc_q;
    sp_d         = sp_q;
    sr_d         = sr_q;
    vec_d        = vec_q;
    memReq_o     = 1'b0;
    memWr_o      = 1'b0;
    memAddr_o    = '0;
    memData_o    = '0;
    trapActive_o = (state_q != IDLE);
    pcWr_o       = 1'b0;
    pcData_o     = '0;
    spWr_o       = 1'b0;
    spData_o     = '0;
    setPriv_o    = 1'b0;
    priv_o       = '0;
    clrSlp_o     = 1'b0;
    irqAck_o     = '0;
    srWrEn_o     = '0;
    srData_o     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid && (instBoundary_i || status_i[4])) begin
          n_d     = win_idx;
          pc_d    = pc_i;
          sp_d    = sp_i;
          sr_d    = status_i;
          state_d = PUSH_PC;
        end
      end
      PUSH_PC: begin
        memReq_o  = 1'b1;
        memWr_o   = 1'b1;
        memAddr_o = sp_q - WORD'(2);
        memData_o = pc_q;
        if (memAck_i) state_d = PUSH_SR;
      end
      PUSH_SR: begin
        memReq_o  = 1'b1;
        memWr_o   = 1'b1;
        memAddr_o = sp_q - WORD'(4);
        memData_o = sr_q;
        if (memAck_i) state_d = RD_VEC;
      end
      RD_VEC: begin
        memReq_o  = 1'b1;
        memAddr_o = VEC_BASE + (WORD'(n_q) << 1);
        if (memAck_i) begin
          vec_d   = memData_i;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        pcWr_o    = 1'b1;
        pcData_o  = vec_q;
        spWr_o    = 1'b1;
        spData_o  = sp_q - WORD'(4);
        setPriv_o = 1'b1;
        priv_o    = n_q;
        irqAck_o  = PLVLS'(1) << n_q;
        clrSlp_o  = sr_q[4];
`ifdef TRAP_SEQ_IE_CLR_EN
        srWrEn_o[0] = 1'b1;
        srData_o    = sr_q;
        srData_o[5] = 1'b0;
        srData_o[4] = 1'b0;
`else
        srWrEn_o = '0;
        srData_o = '0;
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      n_q     <= '0;
      pc_q    <= '0;
      sp_q    <= '0;
      sr_q    <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      sr_q    <= sr_d;
      vec_q   <= vec_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized bench for trap_sequencer: a transaction-level model predicts each trap's
// bus accesses and COMMIT pulses; a bus responder inserts random wait states.
module tb_trap_sequencer;

  localparam logic [15:0] VEC_BASE = 16'hFFC0;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  irq_i;
  logic        instBoundary_i;
  logic [15:0] status_i, pc_i, sp_i;
  logic        memReq_o, memWr_o;
  logic [15:0] memAddr_o, memData_o;
  logic        memAck_i;
  logic [15:0] memData_i;
  logic        trapActive_o, pcWr_o, spWr_o, setPriv_o, clrSlp_o;
  logic [15:0] pcData_o, spData_o, srData_o;
  logic [2:0]  priv_o;
  logic [7:0]  irqAck_o;
  logic [1:0]  srWrEn_o;
  logic        any_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  trap_sequencer #(.WORD(16), .PLVLS(8), .VEC_BASE(VEC_BASE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_i(irq_i), .instBoundary_i(instBoundary_i),
    .status_i(status_i), .pc_i(pc_i), .sp_i(sp_i),
    .memReq_o(memReq_o), .memWr_o(memWr_o), .memAddr_o(memAddr_o), .memData_o(memData_o),
    .memAck_i(memAck_i), .memData_i(memData_i),
    .trapActive_o(trapActive_o), .pcWr_o(pcWr_o), .pcData_o(pcData_o),
    .spWr_o(spWr_o), .spData_o(spData_o), .setPriv_o(setPriv_o), .priv_o(priv_o),
    .clrSlp_o(clrSlp_o), .irqAck_o(irqAck_o), .srWrEn_o(srWrEn_o), .srData_o(srData_o)
  );

  always #5 clk_i = ~clk_i;

  assign any_out = |{memReq_o, memWr_o, memAddr_o, memData_o, trapActive_o, pcWr_o, pcData_o,
                     spWr_o, spData_o, setPriv_o, priv_o, clrSlp_o, irqAck_o, srWrEn_o, srData_o};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Highest requested level above current privilege, -1 if none or interrupts disabled.
  function automatic int winner(input logic [15:0] st, input logic [7:0] irq);
    if (!st[5]) return -1;
    for (int n = 7; n >= 0; n--)
      if (irq[n] && n > int'(st[15:13])) return n;
    return -1;
  endfunction

  task automatic resync();
    rst_ni = 1'b0;
    irq_i  = '0;
    #1;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic run_trap(input logic [15:0] st, input logic [15:0] pc, input logic [15:0] sp,
                          input logic [7:0] irq, input logic ib, input int d0, input int d1,
                          input int d2, input logic drop, input logic [15:0] vec);
    int          w;
    logic        acc;
    logic [15:0] exp_addr[3];
    logic [15:0] exp_data[3];
    int          dl[3];
    @(negedge clk_i);
    if (trapActive_o) resync();
    status_i = st; pc_i = pc; sp_i = sp; irq_i = irq; instBoundary_i = ib;
    memAck_i = 1'($urandom); memData_i = 16'($urandom);
    w   = winner(st, irq);
    acc = (w >= 0) && (ib || st[4]);
    if (!acc) begin
      repeat (3) begin
        @(negedge clk_i);
        check_eq("idle_no_accept", {31'b0, any_out}, 32'd0);
        memAck_i = 1'($urandom);
      end
      irq_i = '0; memAck_i = 1'b0;
      return;
    end
    exp_addr[0] = sp - 16'd2;  exp_data[0] = pc;
    exp_addr[1] = sp - 16'd4;  exp_data[1] = st;
    exp_addr[2] = VEC_BASE + 16'(2 * w); exp_data[2] = 16'd0;
    dl = '{d0, d1, d2};
    for (int a = 0; a < 3; a++) begin
      for (int c = 0; c <= dl[a]; c++) begin
        @(negedge clk_i);
        check_eq("trap_active", {31'b0, trapActive_o}, 32'd1);
        check_eq("mem_req", {31'b0, memReq_o}, 32'd1);
        check_eq("mem_wr", {31'b0, memWr_o}, (a < 2) ? 32'd1 : 32'd0);
        check_eq("mem_addr", {16'b0, memAddr_o}, {16'b0, exp_addr[a]});
        check_eq("mem_data", {16'b0, memData_o}, {16'b0, exp_data[a]});
        check_eq("no_early_commit", {20'b0, pcWr_o, spWr_o, setPriv_o, clrSlp_o, irqAck_o}, 32'd0);
        if (a == 0 && c == 0) begin
          pc_i = 16'($urandom); sp_i = 16'($urandom); status_i = 16'($urandom);
          irq_i = 8'($urandom); instBoundary_i = 1'($urandom);
        end
        if (a == 1 && c == 0 && drop) irq_i = '0;
        memAck_i  = (c == dl[a]);
        memData_i = (a == 2 && c == dl[a]) ? vec : 16'($urandom);
      end
    end
    @(negedge clk_i);
    check_eq("commit_active", {31'b0, trapActive_o}, 32'd1);
    check_eq("commit_no_req", {31'b0, memReq_o}, 32'd0);
    check_eq("pc_wr", {31'b0, pcWr_o}, 32'd1);
    check_eq("pc_data", {16'b0, pcData_o}, {16'b0, vec});
    check_eq("sp_wr", {31'b0, spWr_o}, 32'd1);
    check_eq("sp_data", {16'b0, spData_o}, {16'b0, sp - 16'd4});
    check_eq("set_priv", {31'b0, setPriv_o}, 32'd1);
    check_eq("priv", {29'b0, priv_o}, 32'(w));
    check_eq("irq_ack", {24'b0, irqAck_o}, 32'(1) << w);
    check_eq("clr_slp", {31'b0, clrSlp_o}, {31'b0, st[4]});
`ifdef TRAP_SEQ_IE_CLR_EN
    check_eq("sr_wr_en", {30'b0, srWrEn_o}, 32'd1);
    check_eq("sr_data", {16'b0, srData_o}, {16'b0, st & 16'hFFCF});
`else
    check_eq("sr_wr_en", {30'b0, srWrEn_o}, 32'd0);
    check_eq("sr_data", {16'b0, srData_o}, 32'd0);
`endif
    memAck_i = 1'($urandom); irq_i = '0; instBoundary_i = 1'b0; status_i = '0;
    @(negedge clk_i);
    check_eq("idle_after_commit", {31'b0, any_out}, 32'd0);
    memAck_i = 1'b0;
  endtask

  task automatic run_reset_mid(input logic [15:0] st, input logic [15:0] pc,
                               input logic [15:0] sp, input logic [7:0] irq);
    @(negedge clk_i);
    if (trapActive_o) resync();
    status_i = st; pc_i = pc; sp_i = sp; irq_i = irq; instBoundary_i = 1'b1; memAck_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      memAck_i = 1'b1;
    end
    @(negedge clk_i);
    memAck_i = 1'b0;
    check_eq("rst_in_rd_vec_req", {31'b0, memReq_o}, 32'd1);
    check_eq("rst_in_rd_vec_wr", {31'b0, memWr_o}, 32'd0);
    #2 rst_ni = 1'b0;
    #1 check_eq("rst_async_outs", {31'b0, any_out}, 32'd0);
    irq_i = '0;
    @(negedge clk_i);
    check_eq("rst_held_outs", {31'b0, any_out}, 32'd0);
    rst_ni = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check_eq("rst_no_commit", {31'b0, any_out}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] st;
    rst_ni = 1'b0; irq_i = '0; instBoundary_i = 1'b0; status_i = '0; pc_i = '0; sp_i = '0;
    memAck_i = 1'b0; memData_i = '0;
    #12 check_eq("reset_outs", {31'b0, any_out}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_trap(16'h0020, 16'h0400, 16'h1000, 8'h08, 1'b1, 0, 0, 0, 1'b0, 16'h1234);
    run_trap(16'h4020, 16'h2222, 16'h3000, 8'h0A, 1'b1, 0, 0, 0, 1'b0, 16'h5678);
    run_trap(16'h4020, 16'h2222, 16'h3000, 8'h04, 1'b1, 0, 0, 0, 1'b0, 16'h0);
    run_trap(16'h0000, 16'h2222, 16'h3000, 8'hFF, 1'b1, 0, 0, 0, 1'b0, 16'h0);
    run_trap(16'h0030, 16'h0100, 16'h0800, 8'h02, 1'b0, 0, 0, 0, 1'b0, 16'h9ABC);
    run_trap(16'h0020, 16'h0ABC, 16'h2000, 8'h40, 1'b1, 3, 3, 3, 1'b1, 16'hBEEF);
    run_trap(16'h0020, 16'h0777, 16'h0002, 8'h80, 1'b1, 0, 1, 2, 1'b0, 16'hC0DE);
    run_reset_mid(16'h0020, 16'h0400, 16'h1000, 8'h08);

    for (int i = 0; i < 150; i++) begin
      st    = 16'($urandom);
      st[5] = ($urandom_range(0, 3) != 0);
      st[4] = ($urandom_range(0, 3) == 0);
      run_trap(st, 16'($urandom), 16'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter WORD, 16, datapath and status width in bits.
REQ-002 SHALL have parameter PLVLS, 8, number of priority levels; PW = $clog2(PLVLS).
REQ-003 SHALL have parameter VEC_BASE, 16'hFFC0, byte address of vector table entry 0.
REQ-004 SHALL have ports clk_i input 1 system clock (rising edge); rst_ni input 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports irq_i input PLVLS level requests (index n = priority n); instBoundary_i input 1 CPU at instruction boundary.
REQ-006 SHALL have ports status_i input WORD status register value, with Curr priv [15:13], IE [5] and SLP [4]; pc_i input WORD; sp_i input WORD.
REQ-007 SHALL have ports memReq_o output 1; memWr_o output 1; memAddr_o output WORD; memData_o output WORD; memAck_i input 1; memData_i input WORD.
REQ-008 SHALL have ports trapActive_o output 1 CPU stall; pcWr_o output 1; pcData_o output WORD; spWr_o output 1; spData_o output WORD.
REQ-009 SHALL have ports setPriv_o output 1; priv_o output PW; clrSlp_o output 1; irqAck_o output PLVLS one-hot.
REQ-010 SHALL have ports srWrEn_o output WORD/8 and srData_o output WORD (status byte write).

Function
REQ-011 SHALL treat request n as eligible when irq_i[n]=1, IE=1 and n > Curr priv; the highest eligible index wins.
REQ-012 SHALL accept the winner in IDLE when instBoundary_i=1 or SLP=1, latch n, pc_i, sp_i and status_i, and enter PUSH_PC on the next edge.
REQ-013 SHALL implement FSM states IDLE, PUSH_PC, PUSH_SR, RD_VEC and COMMIT; trapActive_o=1 in every state except IDLE.
REQ-014 SHALL in PUSH_PC drive memReq_o=1, memWr_o=1, memAddr_o=sp-2 and memData_o=latched pc, and advance to PUSH_SR on memAck_i.
REQ-015 SHALL in PUSH_SR write latched status to sp-4, and advance to RD_VEC on memAck_i.
REQ-016 SHALL in RD_VEC drive a read (memWr_o=0) of VEC_BASE+2*n, capture memData_i on memAck_i, and advance to COMMIT.
REQ-017 SHALL make COMMIT one cycle with these single-cycle pulses, then return to IDLE:
- pcWr_o=1, pcData_o=vector
- spWr_o=1, spData_o=sp-4
- setPriv_o=1, priv_o=n
- irqAck_o[n]=1
- clrSlp_o=1 only if latched SLP=1
REQ-018 SHALL hold memReq_o, memAddr_o, memData_o and memWr_o stable until memAck_i; ack is sampled only while memReq_o=1, and an ack in the same cycle as the request completes the access.
REQ-019 SHALL ignore memAck_i while memReq_o=0.
REQ-020 SHALL compute stack addresses modulo 2^WORD (sp=0x0002 gives pushes at 0x0000 and 0xFFFE).
REQ-021 SHALL continue a sequence to COMMIT using the latched n if irq_i[n] deasserts mid-sequence.
REQ-022 SHALL ignore new requests until IDLE and re-evaluate them in the cycle after COMMIT.
REQ-023 SHALL give minimum latency from acceptance to COMMIT of 4 cycles with zero-wait acks, plus one cycle per wait state.
REQ-024 SHALL drive every output other than those named in REQ-014..REQ-017 to 0 outside its owning state.

Reset
REQ-025 SHALL on rst_ni=0 immediately enter IDLE and clear all latches, whether or not a sequence is in flight.
REQ-026 SHALL drive every output to 0 during reset and in IDLE; an interrupted sequence is abandoned with no COMMIT pulses.

Configuration
REQ-027 SHALL with TRAP_SEQ_IE_CLR_EN defined additionally pulse srWrEn_o=2'b01 in COMMIT, with srData_o equal to latched status with IE=0 and SLP=0, so nested traps are masked until software re-enables IE.
REQ-028 SHALL without TRAP_SEQ_IE_CLR_EN tie srWrEn_o and srData_o to 0, so nesting is limited by priority only.

Verification
REQ-029 SHALL cover: status=16'h0020, irq_i=8'h08, instBoundary_i=1, sp=16'h1000, pc=16'h0400, zero-wait acks -> writes 0400@0FFE and 0020@0FFC, read 0xFFC6, COMMIT with priv_o=3, spData_o=16'h0FFC and irqAck_o=8'h08.
REQ-030 SHALL cover: irq_i=8'h0A, Curr priv=2 -> index 3 accepted; irq_i=8'h04 with Curr priv=2 -> no acceptance, trapActive_o stays 0.
REQ-031 SHALL cover: IE=0 with irq_i=8'hFF -> no sequence; status=16'h0030 (SLP=1) with instBoundary_i=0 and irq_i=8'h02 -> sequence runs and clrSlp_o pulses in COMMIT.
REQ-032 SHALL cover: 3-cycle ack delay on each access with irq_i dropped in PUSH_SR -> addresses held stable, COMMIT still uses latched n, and acceptance-to-COMMIT is 13 cycles.
REQ-033 SHALL cover: rst_ni pulsed low in RD_VEC -> outputs 0 asynchronously, no COMMIT pulses; with TRAP_SEQ_IE_CLR_EN, COMMIT shows srWrEn_o=2'b01 and srData_o[5:4]=0.
